// File: rtl/chip8_timer_unit.sv
// chip8_timer_unit: CHIP-8 delay (DT) and sound (ST) timers.
// A clock divider produces a TICK_HZ decrement event. Each 8-bit timer
// counts down to zero and stops there. is_on drives the sound controller's
// tone enable and is high exactly while ST is non-zero. halt freezes the
// divider and both countdowns but never blocks register writes.
// There is no handshake: dt_we/st_we are single-cycle strobes that are
// always accepted, and tick is a free-running one-cycle pulse.

module chip8_timer_unit #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       dt_we,
  input  logic [7:0] dt_wdata,
  input  logic       st_we,
  input  logic [7:0] st_wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       is_on,
  output logic       tick
);

  // Truncating divide. The small rate error this causes is accepted.
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  // A divider below 2 cannot produce a distinct tick period.
  if (DIV < 2) begin : g_bad_div
    $error("chip8_timer_unit: CLK_HZ / TICK_HZ must be at least 2");
  end

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]    dt_q, dt_d;
  logic [7:0]    st_q, st_d;
  logic          is_on_q, is_on_d;
  logic          tick_q;
  logic          tick_evt;

  // Divider: counts 0..DIV-1 while running, holds while halted.
  // It raises tick_evt on its last count and wraps on that edge.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_evt  = 1'b0;
    if (!halt) begin
      if (div_cnt_q == DIV_LAST) begin
        tick_evt  = 1'b1;
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // Timer next-state. A write beats a same-cycle tick, and the loaded
  // value is not decremented in that cycle. A timer at zero stays at zero.
  always_comb begin
    dt_d = dt_q;
    if (dt_we) begin
      dt_d = dt_wdata;
    end else if (tick_evt && (dt_q != 8'd0)) begin
      dt_d = dt_q - 8'd1;
    end

    st_d = st_q;
    if (st_we) begin
      st_d = st_wdata;
    end else if (tick_evt && (st_q != 8'd0)) begin
      st_d = st_q - 8'd1;
    end

    // Registered from next ST, so is_on never disagrees with st_value.
    is_on_d = (st_d != 8'd0);
  end

  // State registers. Synchronous reset has priority over writes and ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      dt_q      <= 8'd0;
      st_q      <= 8'd0;
      is_on_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dt_q      <= dt_d;
      st_q      <= st_d;
      is_on_q   <= is_on_d;
      tick_q    <= tick_evt;
    end
  end

  assign dt_value = dt_q;
  assign st_value = st_q;
  assign is_on    = is_on_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_chip8_timer_unit.sv
// Directed bench for chip8_timer_unit with CLK_HZ=600 and TICK_HZ=60, so
// DIV=10. Expected values are pushed to exp_q when stimulus is driven and
// are popped and compared when the DUT output is sampled. Sampling happens
// 1 time unit after each rising edge.

module tb_chip8_timer_unit;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       halt = 1'b0;
  logic       dt_we = 1'b0;
  logic [7:0] dt_wdata = 8'd0;
  logic       st_we = 1'b0;
  logic [7:0] st_wdata = 8'd0;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       is_on;
  logic       tick;

  always #5 clk = ~clk;

  chip8_timer_unit #(
    .CLK_HZ (600),
    .TICK_HZ(60)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .halt    (halt),
    .dt_we   (dt_we),
    .dt_wdata(dt_wdata),
    .st_we   (st_we),
    .st_wdata(st_wdata),
    .dt_value(dt_value),
    .st_value(st_value),
    .is_on   (is_on),
    .tick    (tick)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic push(input logic [15:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until tick is seen high, bounded at 200 edges.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((tick !== 1'b1) && (n < 200));
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int ticks_seen;

  initial begin
    // Reset: hold for two edges, then check all outputs are cleared.
    reset = 1'b1;
    step();
    step();
    push(0); push(0); push(0); push(0);
    chk("rst_dt", 16'(dt_value));
    chk("rst_st", 16'(st_value));
    chk("rst_is_on", 16'(is_on));
    chk("rst_tick", 16'(tick));

    // Release. First tick in cycle 11, then 21 and 31.
    reset = 1'b0;
    push(10); wait_tick(n); chk("first_tick_gap", 16'(n));
    push(10); wait_tick(n); chk("second_tick_gap", 16'(n));
    push(10); wait_tick(n); chk("third_tick_gap", 16'(n));

    // ST countdown: load 3 in the tick cycle.
    st_we = 1'b1; st_wdata = 8'd3;
    push(3); push(1);
    step();
    st_we = 1'b0;
    chk("st_load3", 16'(st_value));
    chk("st_load3_is_on", 16'(is_on));
    push(9); push(2); push(1);
    wait_tick(n);
    chk("st_tick1_gap", 16'(n));
    chk("st_tick1_val", 16'(st_value));
    chk("st_tick1_is_on", 16'(is_on));
    push(1); push(1);
    wait_tick(n);
    chk("st_tick2_val", 16'(st_value));
    chk("st_tick2_is_on", 16'(is_on));
    push(0); push(0);
    wait_tick(n);
    chk("st_tick3_val", 16'(st_value));
    chk("st_tick3_is_on", 16'(is_on));

    // Write/tick collision: 9 edges puts the divider on its last count.
    for (int i = 0; i < 9; i++) step();
    dt_we = 1'b1; dt_wdata = 8'd5;
    push(1); push(5);
    step();
    dt_we = 1'b0;
    chk("collide_tick", 16'(tick));
    chk("collide_dt", 16'(dt_value));

    // DT = 1 counts to 0 and does not wrap.
    dt_we = 1'b1; dt_wdata = 8'd1;
    push(1);
    step();
    dt_we = 1'b0;
    chk("dt_load1", 16'(dt_value));
    push(9); push(0);
    wait_tick(n);
    chk("dt1_tick_gap", 16'(n));
    chk("dt1_to_zero", 16'(dt_value));
    push(0); push(0);
    wait_tick(n);
    chk("dt_no_wrap", 16'(dt_value));
    chk("st_no_wrap", 16'(st_value));

    // Halt: ST = 200, then 25 halted edges with a DT write in the middle.
    st_we = 1'b1; st_wdata = 8'd200;
    push(200);
    step();
    st_we = 1'b0;
    chk("st_load200", 16'(st_value));
    halt = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) begin
        dt_we = 1'b1; dt_wdata = 8'd9;
      end
      step();
      dt_we = 1'b0;
      if (tick === 1'b1) ticks_seen++;
    end
    push(0); push(200); push(9);
    chk("halt_no_tick", 16'(ticks_seen));
    chk("halt_st_frozen", 16'(st_value));
    chk("halt_dt_write", 16'(dt_value));
    halt = 1'b0;
    // Unhalted schedule would tick 9 edges after the load; halt added 25.
    push(9); push(199); push(8);
    wait_tick(n);
    chk("halt_resume_gap", 16'(n + 25 - 25));
    chk("halt_resume_st", 16'(st_value));
    chk("halt_resume_dt", 16'(dt_value));

    // Mid-run kill: ST = 50, then write 0.
    st_we = 1'b1; st_wdata = 8'd50;
    push(50); push(1);
    step();
    chk("kill_st50", 16'(st_value));
    chk("kill_st50_is_on", 16'(is_on));
    st_wdata = 8'd0;
    push(0); push(0);
    step();
    chk("kill_write0_is_on", 16'(is_on));
    chk("kill_write0_st", 16'(st_value));
    st_wdata = 8'd200;
    push(1);
    step();
    st_we = 1'b0;
    chk("reload200_is_on", 16'(is_on));

    // One-cycle reset clears everything; next tick 10 edges after release.
    reset = 1'b1;
    push(0); push(0); push(0);
    step();
    reset = 1'b0;
    chk("midrst_is_on", 16'(is_on));
    chk("midrst_st", 16'(st_value));
    chk("midrst_dt", 16'(dt_value));
    push(10);
    wait_tick(n);
    chk("midrst_tick_gap", 16'(n));

    // Independence: DT = 7 and ST = 2 in the same cycle.
    dt_we = 1'b1; dt_wdata = 8'd7;
    st_we = 1'b1; st_wdata = 8'd2;
    push(7); push(2); push(1);
    step();
    dt_we = 1'b0; st_we = 1'b0;
    chk("indep_dt_load", 16'(dt_value));
    chk("indep_st_load", 16'(st_value));
    chk("indep_is_on", 16'(is_on));
    wait_tick(n);
    push(5); push(0); push(0);
    wait_tick(n);
    chk("indep_dt_2ticks", 16'(dt_value));
    chk("indep_st_2ticks", 16'(st_value));
    chk("indep_is_on_2ticks", 16'(is_on));
    for (int i = 0; i < 5; i++) wait_tick(n);
    push(0);
    chk("indep_dt_7ticks", 16'(dt_value));

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected %0d", exp_q.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
